// File: rtl/stereo_scan_seq.sv
// rtl/stereo_scan_seq.sv - raster-scan sequencer that reads left/right pixels, emits pairs and writes disparities
// All outputs are registered and take the value decided for the state being entered.
module stereo_scan_seq #(
  parameter int IMG_WID  = 320,
  parameter int IMG_HGT  = 240,
  parameter int MAX_DISP = 16,
  parameter int PIX_W    = 8
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             start_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [1:0]       sel_out,
  output logic [18:0]      row_index_out,
  output logic [18:0]      col_index_out,
  output logic             mem_rd_out,
  output logic             mem_wr_out,
  input  logic             mem_ack_in,
  input  logic [PIX_W-1:0] mem_rdata_in,
  output logic [PIX_W-1:0] mem_wdata_out,
  output logic             pair_valid_out,
  output logic [PIX_W-1:0] left_pix_out,
  output logic [PIX_W-1:0] right_pix_out,
  output logic             pair_oob_out,
  output logic [5:0]       disp_idx_out,
  output logic             last_pair_out,
  input  logic             disp_valid_in,
  input  logic [PIX_W-1:0] disp_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_L,
    S_RD_R,
    S_EMIT,
    S_WAIT_D,
    S_WR_D,
    S_DONE
  } state_t;

  localparam logic [18:0] COL_LAST = 19'(IMG_WID - 1);
  localparam logic [18:0] ROW_LAST = 19'(IMG_HGT - 1);
  localparam logic [5:0]  D_LAST   = 6'(MAX_DISP - 1);
  localparam logic [1:0]  SEL_L    = 2'b00;
  localparam logic [1:0]  SEL_R    = 2'b01;
  localparam logic [1:0]  SEL_D    = 2'b10;

  state_t            state_q, state_d;
  logic [18:0]       row_q, row_d;
  logic [18:0]       col_q, col_d;
  logic [5:0]        d_q, d_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        sel_q, sel_d;
  logic [18:0]       row_idx_q, row_idx_d;
  logic [18:0]       col_idx_q, col_idx_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [PIX_W-1:0]  wdata_q, wdata_d;
  logic [PIX_W-1:0]  left_q, left_d;
  logic [PIX_W-1:0]  right_q, right_d;
  logic              pv_q, pv_d;
  logic              oob_q, oob_d;
  logic              last_q, last_d;

  logic [5:0]        d_inc;
  logic [18:0]       d_ext;
  logic [18:0]       d_next_ext;
  logic              cur_oob;
  logic              next_oob;
  logic              last_pix;
  logic [18:0]       col_adv;
  logic [18:0]       row_adv;

  always_comb begin
    d_inc      = d_q + 6'd1;
    d_ext      = {13'd0, d_q};
    d_next_ext = {13'd0, d_inc};
    cur_oob    = col_q < d_ext;
    next_oob   = col_q < d_next_ext;
    last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    col_adv    = (col_q == COL_LAST) ? 19'd0 : col_q + 19'd1;
    row_adv    = (col_q == COL_LAST) ? row_q + 19'd1 : row_q;

    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    d_d       = d_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sel_d     = sel_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    left_d    = left_q;
    right_d   = right_q;
    pv_d      = 1'b0;
    oob_d     = 1'b0;
    last_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d   = S_RD_L;
          busy_d    = 1'b1;
          row_d     = 19'd0;
          col_d     = 19'd0;
          d_d       = 6'd0;
          rd_d      = 1'b1;
          sel_d     = SEL_L;
          row_idx_d = 19'd0;
          col_idx_d = 19'd0;
        end
      end
      S_RD_L: begin
        if (mem_ack_in) begin
          left_d  = mem_rdata_in;
          rd_d    = 1'b0;
          state_d = S_RD_R;
        end
      end
      S_RD_R: begin
        // Entered from RD_L with rd low so the left request visibly drops first.
        if (cur_oob) begin
          right_d = '0;
          oob_d   = 1'b1;
          pv_d    = 1'b1;
          last_d  = (d_q == D_LAST);
          state_d = S_EMIT;
        end else if (!rd_q) begin
          rd_d      = 1'b1;
          sel_d     = SEL_R;
          row_idx_d = row_q;
          col_idx_d = col_q - d_ext;
        end else if (mem_ack_in) begin
          right_d = mem_rdata_in;
          rd_d    = 1'b0;
          pv_d    = 1'b1;
          last_d  = (d_q == D_LAST);
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (d_q == D_LAST) begin
          state_d = S_WAIT_D;
        end else begin
          d_d     = d_inc;
          state_d = S_RD_R;
          if (!next_oob) begin
            rd_d      = 1'b1;
            sel_d     = SEL_R;
            row_idx_d = row_q;
            col_idx_d = col_q - d_next_ext;
          end
        end
      end
      S_WAIT_D: begin
        if (disp_valid_in) begin
          wdata_d   = disp_in;
          wr_d      = 1'b1;
          sel_d     = SEL_D;
          row_idx_d = row_q;
          col_idx_d = col_q;
          state_d   = S_WR_D;
        end
      end
      S_WR_D: begin
        if (mem_ack_in) begin
          wr_d = 1'b0;
          d_d  = 6'd0;
          if (last_pix) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            row_d     = row_adv;
            col_d     = col_adv;
            rd_d      = 1'b1;
            sel_d     = SEL_L;
            row_idx_d = row_adv;
            col_idx_d = col_adv;
            state_d   = S_RD_L;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= S_IDLE;
      row_q     <= 19'd0;
      col_q     <= 19'd0;
      d_q       <= 6'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_q     <= 2'b00;
      row_idx_q <= 19'd0;
      col_idx_q <= 19'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      pv_q      <= 1'b0;
      oob_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      d_q       <= d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sel_q     <= sel_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      left_q    <= left_d;
      right_q   <= right_d;
      pv_q      <= pv_d;
      oob_q     <= oob_d;
      last_q    <= last_d;
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign sel_out        = sel_q;
  assign row_index_out  = row_idx_q;
  assign col_index_out  = col_idx_q;
  assign mem_rd_out     = rd_q;
  assign mem_wr_out     = wr_q;
  assign mem_wdata_out  = wdata_q;
  assign pair_valid_out = pv_q;
  assign left_pix_out   = left_q;
  assign right_pix_out  = right_q;
  assign pair_oob_out   = oob_q;
  assign disp_idx_out   = d_q;
  assign last_pair_out  = last_q;

endmodule

// File: tb/tb_stereo_scan_seq.sv
// tb/tb_stereo_scan_seq.sv - randomized self-checking bench for stereo_scan_seq against a frame-level reference model
module tb_stereo_scan_seq;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int D      = 2;
  localparam int NPIX   = W * H;
  localparam int BUDGET = 4000;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sel;
    logic [18:0] row;
    logic [18:0] col;
    logic [7:0]  data;
  } acc_t;

  typedef struct packed {
    logic [7:0] left;
    logic [7:0] right;
    logic       oob;
    logic [5:0] idx;
    logic       last;
  } pair_t;

  logic        clk_in;
  logic        reset_n_in;
  logic        start_in;
  logic        busy_out;
  logic        done_out;
  logic [1:0]  sel_out;
  logic [18:0] row_index_out;
  logic [18:0] col_index_out;
  logic        mem_rd_out;
  logic        mem_wr_out;
  logic        mem_ack_in;
  logic [7:0]  mem_rdata_in;
  logic [7:0]  mem_wdata_out;
  logic        pair_valid_out;
  logic [7:0]  left_pix_out;
  logic [7:0]  right_pix_out;
  logic        pair_oob_out;
  logic [5:0]  disp_idx_out;
  logic        last_pair_out;
  logic        disp_valid_in;
  logic [7:0]  disp_in;

  stereo_scan_seq #(.IMG_WID(W), .IMG_HGT(H), .MAX_DISP(D), .PIX_W(8)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .start_in(start_in),
    .busy_out(busy_out), .done_out(done_out), .sel_out(sel_out),
    .row_index_out(row_index_out), .col_index_out(col_index_out),
    .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out), .mem_ack_in(mem_ack_in),
    .mem_rdata_in(mem_rdata_in), .mem_wdata_out(mem_wdata_out),
    .pair_valid_out(pair_valid_out), .left_pix_out(left_pix_out),
    .right_pix_out(right_pix_out), .pair_oob_out(pair_oob_out),
    .disp_idx_out(disp_idx_out), .last_pair_out(last_pair_out),
    .disp_valid_in(disp_valid_in), .disp_in(disp_in)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int          checks_n;
  int          errors_n;
  logic [7:0]  left_img  [0:H-1][0:W-1];
  logic [7:0]  right_img [0:H-1][0:W-1];
  logic [7:0]  disp_vals [0:NPIX];
  acc_t        exp_acc[$];
  pair_t       exp_pair[$];
  int          cnt_rdl, cnt_pair, cnt_wr, cnt_done;
  int          disp_k, disp_delay, ack_wait, hold_cnt;
  bit          disp_wait, pending, ack_rd_prev, ack_wr_prev, frame_active;
  bit          fast_mode, left3_mode, snoise_mode, start_pulse;
  logic [7:0]  lat_data;
  logic [63:0] lat_snap;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a"}, 64'({busy_out, done_out, sel_out, row_index_out, col_index_out,
                              mem_rd_out, mem_wr_out}), 64'd0);
    check_eq({tag, "_b"}, 64'({mem_wdata_out, pair_valid_out, left_pix_out, right_pix_out,
                              pair_oob_out, disp_idx_out, last_pair_out}), 64'd0);
  endtask

  // One clock of monitoring plus driving: sample at negedge, then drive inputs for the next posedge.
  task automatic cycle();
    acc_t        e;
    pair_t       p;
    logic        req;
    bit          arm_now;
    logic [63:0] snap;
    @(negedge clk_in);
    req  = mem_rd_out | mem_wr_out;
    snap = {14'd0, sel_out, row_index_out, col_index_out, mem_wdata_out, mem_rd_out, mem_wr_out};
    check_eq("rd_wr_excl", 64'(mem_rd_out & mem_wr_out), 64'd0);
    if (ack_rd_prev) check_eq("rd_drop", 64'(mem_rd_out), 64'd0);
    if (ack_wr_prev) check_eq("wr_drop", 64'(mem_wr_out), 64'd0);

    if (frame_active) begin
      if (done_out) begin
        cnt_done++;
        check_eq("done_busy", 64'(busy_out), 64'd0);
        check_eq("done_after_ack", 64'(ack_wr_prev), 64'd1);
        check_eq("done_acc_left", 64'(exp_acc.size()), 64'd0);
        check_eq("done_pair_left", 64'(exp_pair.size()), 64'd0);
        frame_active = 1'b0;
      end else begin
        check_eq("busy", 64'(busy_out), 64'd1);
      end
    end else begin
      check_eq("idle_status", 64'({busy_out, done_out}), 64'd0);
    end
    ack_rd_prev = 1'b0;
    ack_wr_prev = 1'b0;

    if (req) begin
      if (!pending) begin
        check_eq("acc_expected", 64'(exp_acc.size() > 0), 64'd1);
        lat_data = 8'h00;
        if (exp_acc.size() > 0) begin
          e = exp_acc.pop_front();
          check_eq("acc_kind", 64'({mem_rd_out, mem_wr_out}), 64'({~e.wr, e.wr}));
          check_eq("acc_sel", 64'(sel_out), 64'(e.sel));
          check_eq("acc_row", 64'(row_index_out), 64'(e.row));
          check_eq("acc_col", 64'(col_index_out), 64'(e.col));
          if (e.wr) check_eq("acc_wdata", 64'(mem_wdata_out), 64'(e.data));
          else if (e.sel == 2'b00) lat_data = left_img[int'(e.row)][int'(e.col)];
          else lat_data = right_img[int'(e.row)][int'(e.col)];
        end
        if (mem_rd_out && sel_out == 2'b00) cnt_rdl++;
        if (mem_wr_out) begin
          cnt_wr++;
          disp_wait = 1'b0;
          disp_k++;
        end
        pending  = 1'b1;
        lat_snap = snap;
        hold_cnt = 1;
        if (fast_mode) ack_wait = 0;
        else if (left3_mode && mem_rd_out && sel_out == 2'b00) ack_wait = 3;
        else ack_wait = int'($urandom_range(0, 3));
      end else begin
        hold_cnt++;
        check_eq("req_stable", snap, lat_snap);
      end
      if (ack_wait == 0) begin
        if (left3_mode && mem_rd_out && sel_out == 2'b00)
          check_eq("left_hold_cycles", 64'(hold_cnt), 64'd4);
        mem_ack_in   = 1'b1;
        mem_rdata_in = lat_data;
        pending      = 1'b0;
        ack_rd_prev  = mem_rd_out;
        ack_wr_prev  = mem_wr_out;
      end else begin
        ack_wait--;
        mem_ack_in   = 1'b0;
        mem_rdata_in = 8'($urandom);
      end
    end else begin
      check_eq("req_dropped", 64'(pending), 64'd0);
      pending      = 1'b0;
      mem_ack_in   = fast_mode ? 1'b1 : ($urandom_range(0, 4) == 0);
      mem_rdata_in = 8'($urandom);
    end

    arm_now = 1'b0;
    if (pair_valid_out) begin
      cnt_pair++;
      check_eq("pair_expected", 64'(exp_pair.size() > 0), 64'd1);
      if (exp_pair.size() > 0) begin
        p = exp_pair.pop_front();
        check_eq("pair_left", 64'(left_pix_out), 64'(p.left));
        check_eq("pair_right", 64'(right_pix_out), 64'(p.right));
        check_eq("pair_oob", 64'(pair_oob_out), 64'(p.oob));
        check_eq("pair_idx", 64'(disp_idx_out), 64'(p.idx));
        check_eq("pair_last", 64'(last_pair_out), 64'(p.last));
        if (p.last) begin
          disp_wait  = 1'b1;
          disp_delay = int'($urandom_range(0, 3));
          arm_now    = 1'b1;
        end
      end
    end else begin
      check_eq("pair_flags_idle", 64'({pair_oob_out, last_pair_out}), 64'd0);
    end

    // Garbage disparities are offered whenever the sequencer should not be listening.
    if (fast_mode) begin
      disp_valid_in = 1'b1;
      disp_in       = disp_vals[disp_k];
    end else if (disp_wait && !arm_now) begin
      if (disp_delay == 0) begin
        disp_valid_in = 1'b1;
        disp_in       = disp_vals[disp_k];
      end else begin
        disp_delay--;
        disp_valid_in = 1'b0;
        disp_in       = 8'($urandom);
      end
    end else begin
      disp_valid_in = ($urandom_range(0, 2) == 0);
      disp_in       = 8'($urandom);
    end
    start_in = start_pulse | (snoise_mode & busy_out & ($urandom_range(0, 5) == 0));
  endtask

  task automatic run_frame(input bit fast, input bit left3, input bit snoise, input int abort_w);
    int n;
    int k;
    fast_mode   = fast;
    left3_mode  = left3;
    snoise_mode = snoise;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        left_img[r][c]  = 8'($urandom);
        right_img[r][c] = 8'($urandom);
      end
    for (int i = 0; i <= NPIX; i++) disp_vals[i] = 8'($urandom);
    if (fast) disp_vals[NPIX-1] = 8'h05;

    exp_acc.delete();
    exp_pair.delete();
    k = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        exp_acc.push_back('{wr: 1'b0, sel: 2'b00, row: 19'(r), col: 19'(c), data: 8'h00});
        for (int d = 0; d < D; d++) begin
          if (c >= d) exp_acc.push_back('{wr: 1'b0, sel: 2'b01, row: 19'(r), col: 19'(c - d), data: 8'h00});
          exp_pair.push_back('{left: left_img[r][c],
                               right: (c >= d) ? right_img[r][c-d] : 8'h00,
                               oob: (c < d), idx: 6'(d), last: (d == D - 1)});
        end
        exp_acc.push_back('{wr: 1'b1, sel: 2'b10, row: 19'(r), col: 19'(c), data: disp_vals[k]});
        k++;
      end

    cnt_rdl = 0; cnt_pair = 0; cnt_wr = 0; cnt_done = 0;
    disp_k = 0; disp_wait = 1'b0; pending = 1'b0;
    ack_rd_prev = 1'b0; ack_wr_prev = 1'b0;

    start_pulse = 1'b1;
    cycle();
    start_pulse  = 1'b0;
    frame_active = 1'b1;
    n = 0;
    while (frame_active && n < BUDGET && !(abort_w >= 0 && cnt_wr > abort_w)) begin
      cycle();
      n++;
    end

    if (abort_w >= 0 && cnt_wr > abort_w) begin
      #2 reset_n_in = 1'b0;
      #1 check_reset_outputs("abort_outputs");
      frame_active = 1'b0;
      pending      = 1'b0;
      ack_rd_prev  = 1'b0;
      ack_wr_prev  = 1'b0;
      disp_wait    = 1'b0;
      exp_acc.delete();
      exp_pair.delete();
      repeat (3) cycle();
      reset_n_in = 1'b1;
    end else begin
      check_eq("frame_finished", 64'(frame_active), 64'd0);
      frame_active = 1'b0;
      repeat (3) cycle();
      check_eq("done_pulses", 64'(cnt_done), 64'd1);
    end
  endtask

  initial begin
    checks_n      = 0;
    errors_n      = 0;
    reset_n_in    = 1'b0;
    start_in      = 1'b0;
    start_pulse   = 1'b0;
    mem_ack_in    = 1'b0;
    mem_rdata_in  = 8'h00;
    disp_valid_in = 1'b0;
    disp_in       = 8'h00;
    frame_active  = 1'b0;
    fast_mode     = 1'b0;
    left3_mode    = 1'b0;
    snoise_mode   = 1'b0;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset_outputs");
    reset_n_in = 1'b1;

    run_frame(1'b1, 1'b0, 1'b0, -1);
    check_eq("fast_rd_l_count", 64'(cnt_rdl), 64'(NPIX));
    check_eq("fast_pair_count", 64'(cnt_pair), 64'(NPIX * D));
    check_eq("fast_wr_count", 64'(cnt_wr), 64'(NPIX));

    run_frame(1'b0, 1'b1, 1'b0, -1);
    run_frame(1'b0, 1'b0, 1'b1, -1);
    run_frame(1'b0, 1'b0, 1'b0, int'($urandom_range(1, NPIX - 2)));
    run_frame(1'b0, 1'b0, 1'b0, -1);
    run_frame(1'b0, 1'b1, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/stereo_scan_seq.md
Name: stereo_scan_seq

Overview:
- Raster-scan sequencer that sits directly upstream of the SRAM address mapper. It drives the mapper's select, row index and column index inputs.
- For each output pixel it does the following, all over a single req/ack memory port:
  - reads the left-image pixel once;
  - reads MAX_DISP right-image candidates at col-d and streams left/right pairs to the matching-cost stage;
  - writes the returned disparity into the disparity image.
- Select encoding toward the mapper: 2'b00 left, 2'b01 right, 2'b10 disparity; 2'b11 is never driven.

Parameters:
- IMG_WID, 320, pixels per row.
- IMG_HGT, 240, rows per image.
- MAX_DISP, 16, disparity candidates per pixel (d = 0..MAX_DISP-1), at most 64.
- PIX_W, 8, pixel and disparity data width.

Ports:
- clk_in  in  1  clock, all state on rising edge.
- reset_n_in  in  1  asynchronous active-low reset.
- start_in  in  1  one-cycle pulse that begins a frame; ignored while busy_out=1.
- busy_out  out  1  high from the cycle after an accepted start through the final write ack.
- done_out  out  1  one-cycle pulse in the cycle after the final disparity write ack.
- sel_out  out  2  image select to the address mapper.
- row_index_out  out  19  row index to the address mapper.
- col_index_out  out  19  column index to the address mapper.
- mem_rd_out  out  1  read request; held until acked.
- mem_wr_out  out  1  write request; held until acked.
- mem_ack_in  in  1  memory acknowledge; read data valid in the same cycle.
- mem_rdata_in  in  PIX_W  memory read data.
- mem_wdata_out  out  PIX_W  write data, equal to the captured disparity.
- pair_valid_out  out  1  one-cycle pulse marking a valid left/right pair.
- left_pix_out  out  PIX_W  current left pixel.
- right_pix_out  out  PIX_W  current right candidate; 0 when out of bounds.
- pair_oob_out  out  1  high with pair_valid_out when col-d < 0.
- disp_idx_out  out  6  d value of the current pair.
- last_pair_out  out  1  high with pair_valid_out when d = MAX_DISP-1.
- disp_valid_in  in  1  disparity result valid from the downstream stage.
- disp_in  in  PIX_W  disparity result.

Behaviour:
Reset:
- All outputs are 0. State is IDLE and row, col and d counters are 0.
- Reset asserted mid-frame aborts immediately. No done_out pulse is produced, and any pending rd/wr drops in the same cycle.

FSM states:
- IDLE: start_in=1 -> RD_L with row=0, col=0, d=0.
- RD_L:
  - drive sel=00, row, col, mem_rd=1;
  - on ack, capture mem_rdata into left_pix, then -> RD_R.
- RD_R:
  - drive sel=01, row, col-d, mem_rd=1;
  - on ack, capture into right_pix, then -> EMIT;
  - if col < d, there is no memory access: right_pix=0, oob=1, and the FSM goes straight to EMIT in the next cycle.
- EMIT:
  - pair_valid_out=1 for exactly one cycle with disp_idx=d;
  - if d < MAX_DISP-1: d++ and -> RD_R;
  - otherwise -> WAIT_D.
- WAIT_D:
  - wait for disp_valid_in=1, then capture disp_in and -> WR_D;
  - disp_valid_in is ignored in every other state.
- WR_D:
  - drive sel=10, row, col, mem_wr=1, mem_wdata=captured value;
  - on ack, advance the pixel and -> RD_L, or -> DONE after the last pixel.
- DONE: done_out=1 for one cycle, busy_out=0, -> IDLE.

Pixel advance:
- d=0, col++.
- If col = IMG_WID-1: col=0 and row++.
- The last pixel is row = IMG_HGT-1, col = IMG_WID-1.

Handshake:
- sel, row, col and wdata stay stable while rd/wr is high.
- rd and wr are never both high.
- rd/wr deassert in the cycle after the ack cycle.
- An ack arriving while no request is pending is ignored.

Widths and timing:
- Indices are zero-extended to 19 bits; the upper bits are 0 for the defaults.
- Minimum cost per in-bounds pair: request cycle with ack plus one EMIT cycle (2 cycles).

Test Plan:
- Reset, then start with mem_ack tied high and disp_valid_in tied high, IMG_WID=4, IMG_HGT=2, MAX_DISP=2:
  - exactly 8 RD_L, 16 pair_valid and 8 writes occur;
  - done_out pulses once, and busy_out falls in the same cycle.
- Pixel (row 1, col 3):
  - RD_L drives sel=00 row=1 col=3;
  - RD_R drives sel=01 col=3 (d=0) then col=2 (d=1);
  - WR_D drives sel=10 row=1 col=3 with wdata = disp_in (e.g. 8'h05).
- col=0, d=1: no mem_rd is issued; pair_valid pulses with right_pix=0, pair_oob=1, disp_idx=1, last_pair=1.
- mem_ack delayed 3 cycles on the left read: mem_rd stays high with stable sel/row/col for 4 cycles, and left_pix equals mem_rdata from the ack cycle (e.g. 8'hA7).
- start_in pulsed while busy: ignored, and counters unchanged.
- reset_n_in dropped during WR_D:
  - mem_wr and all outputs go to 0 asynchronously, with no done_out pulse;
  - a new start begins at row 0, col 0.
